// File: rtl/id_pipe_skid_reg_pkg.sv
// rtl/id_pipe_skid_reg_pkg.sv - shared encodings and entry layout for the pipeline skid registers
package id_pipe_skid_reg_pkg;

  // Occupancy of a two-entry skid stage (main register plus skid register)
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Instruction word shown on the output while no live instruction is held
  localparam logic [31:0] BUBBLE_INST_DEFAULT = 32'h0000_0000;

  // Default field widths of a pipe entry, shared with the ID/EX and EX/MEM successors
  localparam int unsigned ENTRY_PC_W   = 32;
  localparam int unsigned ENTRY_INST_W = 32;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0]   pc;
    logic [ENTRY_INST_W-1:0] inst;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one valid-tagged {pc, inst} register with load and clear
module pipe_entry_reg
  import id_pipe_skid_reg_pkg::*;
#(
  parameter int unsigned       PC_W        = 32,
  parameter int unsigned       INST_W      = 32,
  parameter logic [INST_W-1:0] BUBBLE_INST = INST_W'(BUBBLE_INST_DEFAULT)
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o
);

  logic              valid_q;
  logic [PC_W-1:0]   pc_q;
  logic [INST_W-1:0] inst_q;

  // Clear wins over load and always leaves a bubble, so an empty entry never shows stale data
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= BUBBLE_INST;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= BUBBLE_INST;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      inst_q  <= inst_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/id_pipe_skid_reg.sv
// rtl/id_pipe_skid_reg.sv - IF/ID pipeline register with registered ready, skid entry and flush
module id_pipe_skid_reg
  import id_pipe_skid_reg_pkg::*;
#(
  parameter int unsigned       PC_W        = 32,
  parameter int unsigned       INST_W      = 32,
  parameter logic [INST_W-1:0] BUBBLE_INST = INST_W'(BUBBLE_INST_DEFAULT),
  parameter int unsigned       CNT_W       = 8
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              in_ready,
  input  logic              Branch_Sig,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [1:0]        state_q, state_d;
  logic              in_ready_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic              accept, consume;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              main_valid, skid_valid;
  logic [PC_W-1:0]   main_pc, skid_pc, main_pc_in;
  logic [INST_W-1:0] main_inst, skid_inst, main_inst_in;

  assign accept  = in_valid & in_ready_q;
  assign consume = main_valid & out_ready;

  // Occupancy FSM: decides which entry loads or clears; a flush overrides everything
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (Branch_Sig) begin
      state_d    = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (consume && accept) begin
            main_load = 1'b1;
          end else if (consume) begin
            main_clear = 1'b1;
            state_d    = ST_EMPTY;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so the only movement is skid draining into main
          if (consume && skid_valid) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_pc_in   = main_from_skid ? skid_pc   : in_pc;
  assign main_inst_in = main_from_skid ? skid_inst : in_inst;

  // State, registered ready and saturating flush counter
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      if (Branch_Sig && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  pipe_entry_reg #(
    .PC_W        (PC_W),
    .INST_W      (INST_W),
    .BUBBLE_INST (BUBBLE_INST)
  ) u_main (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .load_i  (main_load),
    .clear_i (main_clear),
    .pc_i    (main_pc_in),
    .inst_i  (main_inst_in),
    .valid_o (main_valid),
    .pc_o    (main_pc),
    .inst_o  (main_inst)
  );

  pipe_entry_reg #(
    .PC_W        (PC_W),
    .INST_W      (INST_W),
    .BUBBLE_INST (BUBBLE_INST)
  ) u_skid (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pc_i    (in_pc),
    .inst_i  (in_inst),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .inst_o  (skid_inst)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_pc    = main_pc;
  assign out_inst  = main_inst;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_pipe_skid_reg.sv
// tb/tb_id_pipe_skid_reg.sv - self-checking bench for id_pipe_skid_reg
module tb_id_pipe_skid_reg;

  localparam logic [31:0] BUB = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        Branch_Sig = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_inst;
  logic [7:0]  flush_cnt;

  logic        in_ready2, out_valid2;
  logic [31:0] out_pc2, out_inst2;
  logic [1:0]  flush_cnt2;

  always #5 CLK = ~CLK;

  id_pipe_skid_reg #(.PC_W(32), .INST_W(32), .BUBBLE_INST(BUB), .CNT_W(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_ready(in_ready), .Branch_Sig(Branch_Sig), .out_valid(out_valid), .out_pc(out_pc),
    .out_inst(out_inst), .out_ready(out_ready), .flush_cnt(flush_cnt)
  );

  id_pipe_skid_reg #(.PC_W(32), .INST_W(32), .CNT_W(2)) dut2 (
    .CLK(CLK), .RSTN(RSTN), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_ready(in_ready2), .Branch_Sig(Branch_Sig), .out_valid(out_valid2), .out_pc(out_pc2),
    .out_inst(out_inst2), .out_ready(out_ready), .flush_cnt(flush_cnt2)
  );

  int total = 0;
  int bad = 0;

  // Reference model: a FIFO of held entries of capacity two
  logic [31:0] m_pc[$];
  logic [31:0] m_inst[$];
  logic        m_ready;
  int          m_cnt, m_cnt2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic        live;
    logic [31:0] epc, einst;
    live  = (m_pc.size() > 0);
    epc   = live ? m_pc[0] : 32'h0;
    einst = live ? m_inst[0] : BUB;
    chk("out_valid", 64'(out_valid), 64'(live));
    chk("out_pc", 64'(out_pc), 64'(epc));
    chk("out_inst", 64'(out_inst), 64'(einst));
    chk("in_ready", 64'(in_ready), 64'(m_ready));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_cnt));
    chk("flush_cnt2", 64'(flush_cnt2), 64'(m_cnt2));
    chk("out_inst2", 64'(out_inst2), 64'(live ? m_inst[0] : 32'h0));
    chk("out_valid2", 64'(out_valid2), 64'(live));
  endtask

  task automatic model_reset();
    m_pc.delete();
    m_inst.delete();
    m_ready = 1'b1;
    m_cnt = 0;
    m_cnt2 = 0;
  endtask

  // One clock: drive inputs, advance the model, then check after the edge
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                     input logic ordy, input logic br);
    logic acc, cons;
    in_valid = v; in_pc = pc; in_inst = inst; out_ready = ordy; Branch_Sig = br;
    acc  = v && m_ready;
    cons = (m_pc.size() > 0) && ordy;
    if (cons) begin
      void'(m_pc.pop_front());
      void'(m_inst.pop_front());
    end
    if (br) begin
      m_pc.delete();
      m_inst.delete();
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else if (acc) begin
      m_pc.push_back(pc);
      m_inst.push_back(inst);
    end
    m_ready = (m_pc.size() < 2);
    @(posedge CLK);
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted mid-cycle with fetch still presenting data
  task automatic do_reset();
    @(negedge CLK);
    #2;
    in_valid = 1'b1; in_pc = 32'hdead_0000; in_inst = 32'hbeef; Branch_Sig = 1'b0;
    RSTN = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge CLK);
    RSTN = 1'b1;
    in_valid = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] next_pc;
    logic [1:0]  sat_exp [5];
    logic        v, r, b;
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    model_reset();

    // Reset while occupied and after a flush
    do_reset();
    cyc(1, 32'h40, 32'h11, 0, 0);
    cyc(0, 32'h0, 32'h0, 0, 1);
    cyc(1, 32'h44, 32'h12, 0, 0);
    do_reset();
    chk("rst_out_inst", 64'(out_inst), 64'(BUB));
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming at full rate
    cyc(1, 32'h0, 32'hA1, 1, 0);
    chk("stream0_pc", 64'(out_pc), 64'h0);
    cyc(1, 32'h4, 32'hA2, 1, 0);
    chk("stream1_inst", 64'(out_inst), 64'hA2);
    cyc(1, 32'h8, 32'hA3, 1, 0);
    chk("stream2_pc", 64'(out_pc), 64'h8);
    chk("stream2_ready", 64'(in_ready), 64'd1);
    cyc(0, 32'h0, 32'h0, 1, 0);

    // Stall fills the skid entry, then drains in order
    do_reset();
    cyc(1, 32'h10, 32'hB1, 0, 0);
    cyc(1, 32'h14, 32'hB2, 0, 0);
    chk("stall_ready", 64'(in_ready), 64'd0);
    chk("stall_pc", 64'(out_pc), 64'h10);
    cyc(1, 32'h18, 32'hB3, 0, 0);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("drain_pc", 64'(out_pc), 64'h14);
    chk("drain_ready", 64'(in_ready), 64'd1);
    cyc(0, 32'h0, 32'h0, 1, 0);

    // Flush while full drops both held and incoming entries
    do_reset();
    cyc(1, 32'h20, 32'hC1, 0, 0);
    cyc(1, 32'h24, 32'hC2, 0, 0);
    cyc(1, 32'h28, 32'hC3, 0, 1);
    chk("flushf_valid", 64'(out_valid), 64'd0);
    chk("flushf_cnt", 64'(flush_cnt), 64'd1);
    cyc(0, 32'h0, 32'h0, 1, 0);
    cyc(0, 32'h0, 32'h0, 1, 0);

    // Flush in the same cycle as a consume
    do_reset();
    cyc(1, 32'h30, 32'hD1, 0, 0);
    chk("flushc_pre_pc", 64'(out_pc), 64'h30);
    cyc(0, 32'h0, 32'h0, 1, 1);
    chk("flushc_valid", 64'(out_valid), 64'd0);

    // Counter saturation on the 2-bit instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 32'h0, 32'h0, 0, 1);
      chk("sat_cnt2", 64'(flush_cnt2), 64'(sat_exp[i]));
    end

    // Randomized traffic against the FIFO model
    do_reset();
    next_pc = 32'h1000;
    for (int n = 0; n < 2000; n++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      b = ($urandom_range(0, 15) == 0);
      if (v && m_ready && !b) begin
        cyc(v, next_pc, $urandom, r, b);
        next_pc = next_pc + 32'd4;
      end else begin
        cyc(v, next_pc, in_inst, r, b);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
